// File: rtl/exp_sequencer.sv
// exp_sequencer: upstream sequencer for the node array's Metropolis acceptance exponent.
//
// After reset a serial restoring divider fills a table with floor(2^16/k) for
// k = 1..MAX_ORDER (17 cycles per entry, one quotient bit per cycle, MSB first).
// Once the table is built, each accepted start produces one init/run/fin sequence
// on the broadcast node controls, with exp_recip carrying 1/k (unsigned Q1.16)
// for every cycle of exp_run.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high
//   start        in   one-cycle sequence request
//   order        in   number of series terms, sampled with start
//   table_ready  out  1/k table built; start only accepted when high
//   busy         out  sequence in progress (init through fin)
//   done         out  one-cycle pulse coincident with exp_fin
//   exp_init     out  one-cycle pulse: nodes clear accumulators
//   exp_run      out  high for order cycles, one term per cycle
//   exp_fin      out  one-cycle pulse: nodes finalise result
//   exp_recip    out  floor(2^16/k) while exp_run is high, 0 otherwise
module exp_sequencer #(
  parameter int unsigned MAX_ORDER = 16,
  parameter int unsigned ORDER_LOG = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ORDER_LOG-1:0] order,
  output logic                 table_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 exp_init,
  output logic                 exp_run,
  output logic                 exp_fin,
  output logic [16:0]          exp_recip
);

  // Table is sized to the full k counter range so any counter value is a legal index.
  localparam int unsigned          TblDepth = 2 ** ORDER_LOG;
  localparam logic [ORDER_LOG-1:0] MaxK     = ORDER_LOG'(MAX_ORDER);
  localparam logic [ORDER_LOG-1:0] OneK     = ORDER_LOG'(1);
  localparam logic [4:0]           LastBit  = 5'd16;

  typedef enum logic [2:0] {
    StTbl,
    StIdle,
    StInit,
    StRun,
    StFin
  } state_e;

  state_e               state_q, state_d;

  // Divider state
  logic [4:0]           bit_q, bit_d;
  logic [ORDER_LOG-1:0] div_k_q, div_k_d;
  logic [16:0]          rem_q, rem_d;
  logic [15:0]          quo_q, quo_d;
  logic                 tbl_done_q, tbl_done_d;
  logic [17:0]          rem_shift;
  logic [16:0]          rem_next;
  logic                 q_bit;
  logic                 tbl_we;
  logic [16:0]          tbl_wdata;
  logic [16:0]          recip_q [TblDepth];

  // Sequence state
  logic [ORDER_LOG-1:0] run_k_q, run_k_d;
  logic [ORDER_LOG-1:0] run_n_q, run_n_d;
  logic [ORDER_LOG-1:0] order_eff;
  logic                 accept;

  // Registered outputs
  logic                 table_ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 exp_init_q;
  logic                 exp_run_q;
  logic                 exp_fin_q;
  logic [16:0]          exp_recip_q;
  logic [16:0]          exp_recip_d;

  // One restoring-division step. The dividend 2^16 has a single 1 at its MSB,
  // which is shifted in on the first step of each k.
  always_comb begin
    rem_shift = {rem_q, (bit_q == 5'd0)};
    q_bit     = (rem_shift >= 18'(div_k_q));
    rem_next  = q_bit ? 17'(rem_shift - 18'(div_k_q)) : 17'(rem_shift);
    tbl_wdata = {quo_q, q_bit};
  end

  always_comb begin
    order_eff = (order > MaxK) ? MaxK : order;
    accept    = start && table_ready_q && (order != '0);
  end

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    div_k_d    = div_k_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    tbl_done_d = tbl_done_q;
    tbl_we     = 1'b0;
    run_k_d    = run_k_q;
    run_n_d    = run_n_q;

    unique case (state_q)
      StTbl: begin
        if (tbl_done_q) begin
          // One extra cycle after the last write so table_ready rises at 17*MAX_ORDER.
          state_d = StIdle;
        end else begin
          rem_d = rem_next;
          quo_d = {quo_q[14:0], q_bit};
          if (bit_q == LastBit) begin
            tbl_we = ~reset;
            bit_d  = 5'd0;
            rem_d  = '0;
            quo_d  = '0;
            if (div_k_q == MaxK) begin
              tbl_done_d = 1'b1;
            end else begin
              div_k_d = div_k_q + OneK;
            end
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
      end
      StIdle: begin
        if (accept) begin
          state_d = StInit;
          run_n_d = order_eff;
        end
      end
      StInit: begin
        state_d = StRun;
        run_k_d = OneK;
      end
      StRun: begin
        if (run_k_q == run_n_q) begin
          state_d = StFin;
        end else begin
          run_k_d = run_k_q + OneK;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StTbl;
      end
    endcase
  end

  // Registered table read addressed by the next k, so exp_recip lines up with exp_run.
  always_comb begin
    exp_recip_d = '0;
    if (state_d == StRun) begin
      exp_recip_d = recip_q[run_k_d];
    end
  end

  // Table has no reset: every entry that can be read is rewritten after each reset.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      recip_q[div_k_q] <= tbl_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StTbl;
      bit_q         <= 5'd0;
      div_k_q       <= OneK;
      rem_q         <= '0;
      quo_q         <= '0;
      tbl_done_q    <= 1'b0;
      run_k_q       <= '0;
      run_n_q       <= '0;
      table_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      exp_init_q    <= 1'b0;
      exp_run_q     <= 1'b0;
      exp_fin_q     <= 1'b0;
      exp_recip_q   <= '0;
    end else begin
      state_q       <= state_d;
      bit_q         <= bit_d;
      div_k_q       <= div_k_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      tbl_done_q    <= tbl_done_d;
      run_k_q       <= run_k_d;
      run_n_q       <= run_n_d;
      table_ready_q <= (state_d != StTbl);
      busy_q        <= (state_d == StInit) || (state_d == StRun) || (state_d == StFin);
      done_q        <= (state_d == StFin);
      exp_init_q    <= (state_d == StInit);
      exp_run_q     <= (state_d == StRun);
      exp_fin_q     <= (state_d == StFin);
      exp_recip_q   <= exp_recip_d;
    end
  end

  assign table_ready = table_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign exp_init    = exp_init_q;
  assign exp_run     = exp_run_q;
  assign exp_fin     = exp_fin_q;
  assign exp_recip   = exp_recip_q;

endmodule

// File: tb/tb_exp_sequencer.sv
// Scoreboard bench for exp_sequencer: stimulus tasks push the expected
// init/run/fin events with their cycle numbers; a negedge monitor pops and
// compares whenever the DUT drives any control output.
module tb_exp_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  order = 5'd0;
  logic        table_ready;
  logic        busy;
  logic        done;
  logic        exp_init;
  logic        exp_run;
  logic        exp_fin;
  logic [16:0] exp_recip;

  exp_sequencer #(
    .MAX_ORDER(16),
    .ORDER_LOG(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .order      (order),
    .table_ready(table_ready),
    .busy       (busy),
    .done       (done),
    .exp_init   (exp_init),
    .exp_run    (exp_run),
    .exp_fin    (exp_fin),
    .exp_recip  (exp_recip)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_vec = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int cyc;
    bit init;
    bit run;
    bit fin;
    int recip;
  } ev_t;

  ev_t sb[$];

  // floor(65536/k), k = 0..16 (entry 0 unused)
  int recip_tbl[17] = '{0, 65536, 32768, 21845, 16384, 13107, 10922, 9362, 8192,
                        7281, 6553, 5957, 5461, 5041, 4681, 4369, 4096};

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, act, exp);
    end
  endtask

  task automatic push(input int c, input bit i, input bit r, input bit f, input int rc);
    ev_t e;
    e.cyc   = c;
    e.init  = i;
    e.run   = r;
    e.fin   = f;
    e.recip = rc;
    sb.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      check("ctrl_exclusive", int'($countones({exp_init, exp_run, exp_fin}) <= 1), 1);
      check("done_vs_fin", int'(done), int'(exp_fin));
      if (!exp_run) check("recip_idle", int'(exp_recip), 0);
      if (exp_init || exp_run || exp_fin) begin
        if (sb.size() == 0) begin
          check("unexpected_ctrl", int'({exp_init, exp_run, exp_fin}), 0);
        end else begin
          e = sb.pop_front();
          check("event_cycle", edge_cnt, e.cyc);
          check("exp_init", int'(exp_init), int'(e.init));
          check("exp_run", int'(exp_run), int'(e.run));
          check("exp_fin", int'(exp_fin), int'(e.fin));
          check("exp_recip", int'(exp_recip), e.recip);
          check("busy_active", int'(busy), 1);
        end
      end
    end
  end

  // Reset, then watch the 272-cycle table build with a stray start at cycle 100.
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("rst_table_ready", int'(table_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_exp_init", int'(exp_init), 0);
    check("rst_exp_run", int'(exp_run), 0);
    check("rst_exp_fin", int'(exp_fin), 0);
    check("rst_exp_recip", int'(exp_recip), 0);
    mon_en = 1'b1;
    reset  = 1'b0;
    for (int c = 0; c <= 272; c++) begin
      @(negedge clk);
      check("table_ready", int'(table_ready), (c >= 272) ? 1 : 0);
      if (c == 100) begin
        start = 1'b1;
        order = 5'd4;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  // Start at the current cycle t; optional stray start pulse at t+3.
  task automatic run_seq(input int ord, input int n, input bit pulse);
    int t;
    t = edge_cnt;
    push(t + 1, 1'b1, 1'b0, 1'b0, 0);
    for (int k = 1; k <= n; k++) push(t + 1 + k, 1'b0, 1'b1, 1'b0, recip_tbl[k]);
    push(t + 2 + n, 1'b0, 1'b0, 1'b1, 0);
    start = 1'b1;
    order = ord[4:0];
    for (int c = 1; c <= n + 3; c++) begin
      @(negedge clk);
      start = pulse && (c == 3);
      if (pulse && c == 3) order = 5'd4;
      check("busy", int'(busy), (c <= n + 2) ? 1 : 0);
    end
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);

    do_reset();

    run_seq(4, 4, 1'b0);
    run_seq(16, 16, 1'b0);
    run_seq(20, 16, 1'b0);

    // order = 0 is ignored
    start = 1'b1;
    order = 5'd0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      check("order0_busy", int'(busy), 0);
    end

    run_seq(4, 4, 1'b1);

    // Back-to-back: second start lands in the cycle busy drops
    run_seq(1, 1, 1'b0);
    run_seq(1, 1, 1'b0);

    // Reset during the 2nd exp_run cycle
    t = edge_cnt;
    push(t + 1, 1'b1, 1'b0, 1'b0, 0);
    push(t + 2, 1'b0, 1'b1, 1'b0, 65536);
    push(t + 3, 1'b0, 1'b1, 1'b0, 32768);
    start = 1'b1;
    order = 5'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    check("abort_sb_drained", sb.size(), 0);
    run_seq(2, 2, 1'b0);

    repeat (4) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
